// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

    // Next-PC source selector; encodings 5..7 fall back to sequential fetch.
    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JALR   = 3'd2,
        RET    = 3'd3,
        TRAP   = 3'd4
    } pcsel_e;

    // Byte distance between consecutive 32-bit instructions.
    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack.
// A push overwrites the oldest entry once the stack is full.
// A pop on an empty stack is ignored.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    top_q, top_d, wr_ptr;
    logic [CW-1:0]    count_q, count_d;

    assign wr_ptr   = top_q + PW'(1);
    assign top_data = mem_q[top_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(RAS_DEPTH));

    // Pointer and count update. The pointer wraps naturally;
    // the count saturates at the depth.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        if (push) begin
            top_d = wr_ptr;
            if (!full) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && !empty) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Entry storage. The contents are don't-care after reset, so this block has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with next-PC selection, misaligned-target
// trapping and a return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       pcsel,
    input  logic [WIDTH-1:0] immop,
    input  logic [WIDTH-1:0] rs1,
    input  logic             call,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned,
    output logic             ras_underflow,
    output logic             ras_empty,
    output logic             ras_full
);

    pcsel_e           sel;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] br_tgt, jalr_sum, jalr_tgt, ras_top;
    logic             misaligned_q, misaligned_d;
    logic             underflow_q, underflow_d;
    logic             push, pop;

    assign sel      = pcsel_e'(pcsel);
    assign pc_plus4 = pc_q + WIDTH'(PC_INC);
    assign br_tgt   = pc_q + immop;
    assign jalr_sum = rs1 + immop;
    assign jalr_tgt = jalr_sum & ~WIDTH'(1);

    assign pc            = pc_q;
    assign misaligned    = misaligned_q;
    assign ras_underflow = underflow_q;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus4),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Next-PC selection, alignment trap and stack control. A stall holds
    // everything and clears the one-cycle flags.
    always_comb begin
        pc_d         = pc_plus4;
        misaligned_d = 1'b0;
        underflow_d  = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        case (sel)
            BRANCH: begin
                if (br_tgt[1]) begin
                    pc_d         = TRAP_VEC;
                    misaligned_d = 1'b1;
                end else begin
                    pc_d = br_tgt;
                    push = call;
                end
            end
            JALR: begin
                if (jalr_tgt[1]) begin
                    pc_d         = TRAP_VEC;
                    misaligned_d = 1'b1;
                end else begin
                    pc_d = jalr_tgt;
                    push = call;
                end
            end
            RET: begin
                if (ras_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    pc_d = ras_top;
                    pop  = 1'b1;
                end
            end
            TRAP:    pc_d = TRAP_VEC;
            default: pc_d = pc_plus4;
        endcase
        if (!en) begin
            pc_d         = pc_q;
            misaligned_d = 1'b0;
            underflow_d  = 1'b0;
            push         = 1'b0;
            pop          = 1'b0;
        end
    end

    // PC and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit with hand-computed expected PCs and flags.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  pcsel;
    logic [31:0] immop;
    logic [31:0] rs1;
    logic        call;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        ras_underflow;
    logic        ras_empty;
    logic        ras_full;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(
        .WIDTH     (32),
        .RESET_PC  (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pcsel         (pcsel),
        .immop         (immop),
        .rs1           (rs1),
        .call          (call),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misaligned    (misaligned),
        .ras_underflow (ras_underflow),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
    task automatic step(input logic e, input logic [2:0] sel, input logic [31:0] imm,
                        input logic [31:0] r, input logic c);
        en    = e;
        pcsel = sel;
        immop = imm;
        rs1   = r;
        call  = c;
        @(posedge clk);
        #1;
    endtask

    // Jump to an absolute aligned address without pushing.
    task automatic goto(input logic [31:0] addr);
        step(1'b1, 3'd2, 32'h0, addr, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        pcsel = 3'd0;
        immop = '0;
        rs1   = '0;
        call  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_pc", pc, 32'h0);
        check_eq("reset_pc_plus4", pc_plus4, 32'h4);
        check_eq("reset_misaligned", 32'(misaligned), 32'h0);
        check_eq("reset_underflow", 32'(ras_underflow), 32'h0);
        check_eq("reset_empty", 32'(ras_empty), 32'h1);
        check_eq("reset_full", 32'(ras_full), 32'h0);
        rst_n = 1'b1;

        // Sequential fetch.
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
            check_eq($sformatf("seq_%0d", i), pc, 32'(i * 4));
        end
        check_eq("seq_misaligned", 32'(misaligned), 32'h0);
        check_eq("seq_empty", 32'(ras_empty), 32'h1);

        // Branch-and-link backwards, then return.
        goto(32'h10);
        check_eq("goto_10", pc, 32'h10);
        step(1'b1, 3'd1, 32'hFFFF_FFF8, 32'h0, 1'b1);
        check_eq("branch_call_pc", pc, 32'h08);
        check_eq("branch_call_nonempty", 32'(ras_empty), 32'h0);
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0);
        check_eq("ret_pc", pc, 32'h14);
        check_eq("ret_empty", 32'(ras_empty), 32'h1);

        // Misaligned JALR traps and suppresses the push.
        step(1'b1, 3'd2, 32'h2, 32'h201, 1'b1);
        check_eq("jalr_mis_pc", pc, 32'h100);
        check_eq("jalr_mis_flag", 32'(misaligned), 32'h1);
        check_eq("jalr_mis_nopush", 32'(ras_empty), 32'h1);
        step(1'b1, 3'd2, 32'h3, 32'h201, 1'b0);
        check_eq("jalr_ok_pc", pc, 32'h204);
        check_eq("jalr_ok_flag_clear", 32'(misaligned), 32'h0);

        // Fill the stack past its depth; the fifth push drops the oldest entry.
        for (int i = 0; i < 5; i++) begin
            goto(32'(i * 32));
            step(1'b1, 3'd2, 32'h0, 32'h300, 1'b1);
            check_eq($sformatf("call_pc_%0d", i), pc, 32'h300);
            check_eq($sformatf("call_full_%0d", i), 32'(ras_full), (i >= 3) ? 32'h1 : 32'h0);
        end
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0);
        check_eq("pop_84", pc, 32'h84);
        check_eq("pop_full_clear", 32'(ras_full), 32'h0);
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0);
        check_eq("pop_64", pc, 32'h64);
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0);
        check_eq("pop_44", pc, 32'h44);
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0);
        check_eq("pop_24", pc, 32'h24);
        check_eq("pop_empty", 32'(ras_empty), 32'h1);
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0);
        check_eq("underflow_pc", pc, 32'h28);
        check_eq("underflow_flag", 32'(ras_underflow), 32'h1);
        check_eq("underflow_empty", 32'(ras_empty), 32'h1);
        step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
        check_eq("underflow_one_cycle", 32'(ras_underflow), 32'h0);
        check_eq("after_underflow_pc", pc, 32'h2C);

        // Misaligned branch, then a stall clears the flag and holds everything.
        step(1'b1, 3'd1, 32'h2, 32'h0, 1'b1);
        check_eq("br_mis_pc", pc, 32'h100);
        check_eq("br_mis_flag", 32'(misaligned), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd1, 32'h40, 32'h0, 1'b1);
            check_eq($sformatf("stall_pc_%0d", i), pc, 32'h100);
        end
        check_eq("stall_flag_clear", 32'(misaligned), 32'h0);
        check_eq("stall_no_push", 32'(ras_empty), 32'h1);
        step(1'b1, 3'd1, 32'h40, 32'h0, 1'b1);
        check_eq("unstall_pc", pc, 32'h140);
        check_eq("unstall_push", 32'(ras_empty), 32'h0);

        // Trap request and an undefined selector.
        step(1'b1, 3'd4, 32'h0, 32'h0, 1'b0);
        check_eq("trap_pc", pc, 32'h100);
        step(1'b1, 3'd7, 32'h40, 32'h0, 1'b1);
        check_eq("sel7_seq_pc", pc, 32'h104);

        // Asynchronous reset between edges.
        en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_pc", pc, 32'h0);
        check_eq("async_reset_empty", 32'(ras_empty), 32'h1);
        #1;
        rst_n = 1'b1;

        // Wrap-around at the top of the address space.
        goto(32'hFFFF_FFFC);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        step(1'b1, 3'd0, 32'h0, 32'h0, 1'b0);
        check_eq("wrap_pc", pc, 32'h0);
        check_eq("wrap_no_flag", 32'(misaligned), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
